// File: rtl/core_pkg.sv
// Shared types and default sizes for the common data bus producer side.
package core_pkg;

  // Default sizes of the CDB slice; the arbiter's parameters default to these.
  localparam int CDB_NUM_FU     = 4;
  localparam int CDB_LANES      = 2;
  localparam int CDB_PHYS_W     = 6;
  localparam int CDB_ROB_W      = 6;
  localparam int CDB_FIFO_DEPTH = 4;

  // One completed result as buffered per FU and broadcast on a CDB lane.
  // has_dst = 0 marks results that complete in the ROB but wake nothing up.
  typedef struct packed {
    logic                  has_dst;
    logic [CDB_PHYS_W-1:0] dst_tag;
    logic [31:0]           value;
    logic [CDB_ROB_W-1:0]  rob_tag;
  } cdb_entry_t;

endpackage : core_pkg

// File: rtl/cdb_fu_fifo.sv
// Completion FIFO for one functional unit. Holds finished results until the
// arbiter grants the unit a CDB lane. No pass-through: a pushed entry is only
// visible at the head after the push edge, and a full FIFO refuses pushes
// even in a cycle where it is being popped.
module cdb_fu_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;
  cdb_entry_t    mem [DEPTH];

  // Full/empty come from the registered count only, so fu_ready never
  // depends on a same-cycle pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush drops everything buffered and
  // wins over a push or pop in the same cycle. DEPTH is a power of two, so
  // the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only; validity is tracked by the count above.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule : cdb_fu_fifo

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each functional unit pushes results into its own
// completion FIFO; every cycle up to CDB_W non-empty FIFOs are granted in
// round-robin order starting at rr_ptr, and their heads are registered onto
// the CDB lanes (first grant on lane 0). Every granted lane reports ROB
// completion; only results with a destination raise cdb_valid.
//
// Handshake: fu_valid[i] && fu_ready[i] at a rising edge is a push of that
// unit's result. fu_ready[i] is high whenever FIFO i holds fewer than
// FIFO_DEPTH entries, is derived from registered state only, and must not be
// assumed to rise in the cycle of a pop. The CDB side has no back-pressure:
// each cdb_valid / rob_cmpl_valid is a one-cycle pulse per entry.
module cdb_arbiter
  import core_pkg::*;
#(
  parameter int NUM_FU     = CDB_NUM_FU,
  parameter int CDB_W      = CDB_LANES,
  parameter int PHYS_W     = CDB_PHYS_W,
  parameter int ROB_W      = CDB_ROB_W,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_pipeline,
  input  logic [NUM_FU-1:0]              fu_valid,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [NUM_FU-1:0][PHYS_W-1:0]  fu_dst_tag,
  input  logic [NUM_FU-1:0][31:0]        fu_value,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_tag,
  input  logic [NUM_FU-1:0]              fu_has_dst,
  output logic [CDB_W-1:0]               cdb_valid,
  output logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
  output logic [CDB_W-1:0][31:0]         cdb_value,
  output logic [CDB_W-1:0][ROB_W-1:0]    cdb_rob_tag,
  output logic [CDB_W-1:0]               rob_cmpl_valid
);

  localparam int RR_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int LANE_IDX_W = (CDB_W > 1) ? $clog2(CDB_W) : 1;

  cdb_entry_t          push_entry [NUM_FU];
  cdb_entry_t          fifo_head  [NUM_FU];
  logic [NUM_FU-1:0]   fifo_full;
  logic [NUM_FU-1:0]   fifo_empty;
  logic [NUM_FU-1:0]   grant;

  cdb_entry_t          lane_entry [CDB_W];
  logic [CDB_W-1:0]    lane_gnt;
  logic [RR_W-1:0]     rr_ptr;
  logic [RR_W-1:0]     rr_next;

  // One completion FIFO per functional unit.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign push_entry[g] = '{has_dst: fu_has_dst[g],
                             dst_tag: fu_dst_tag[g],
                             value:   fu_value[g],
                             rob_tag: fu_rob_tag[g]};
    assign fu_ready[g]   = !fifo_full[g];

    cdb_fu_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_pipeline),
      .push       (fu_valid[g]),
      .push_entry (push_entry[g]),
      .pop        (grant[g]),
      .full       (fifo_full[g]),
      .empty      (fifo_empty[g]),
      .head       (fifo_head[g])
    );
  end

  // Round-robin select: walk FU indices from rr_ptr with wrap, granting the
  // first CDB_W non-empty FIFOs in lane order. rr_next points one past the
  // last granted unit, or stays put when nothing is granted.
  always_comb begin : arb_comb
    int lane;
    int idx;
    grant   = '0;
    lane_gnt = '0;
    rr_next = rr_ptr;
    for (int l = 0; l < CDB_W; l++) lane_entry[l] = '0;
    lane = 0;
    idx  = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!fifo_empty[RR_W'(idx)] && (lane < CDB_W)) begin
        grant[RR_W'(idx)]                = 1'b1;
        lane_gnt[LANE_IDX_W'(lane)]      = 1'b1;
        lane_entry[LANE_IDX_W'(lane)]    = fifo_head[RR_W'(idx)];
        rr_next = RR_W'(((idx + 1) == NUM_FU) ? 0 : (idx + 1));
        lane = lane + 1;
      end
    end
  end

  // Round-robin pointer; flush restarts the scan at unit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (flush_pipeline) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

  // CDB output register. Ungranted lanes carry zero data (lane_entry is zero
  // for them); a flush cycle broadcasts nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid      <= '0;
      cdb_tag        <= '0;
      cdb_value      <= '0;
      cdb_rob_tag    <= '0;
      rob_cmpl_valid <= '0;
    end else if (flush_pipeline) begin
      cdb_valid      <= '0;
      cdb_tag        <= '0;
      cdb_value      <= '0;
      cdb_rob_tag    <= '0;
      rob_cmpl_valid <= '0;
    end else begin
      for (int l = 0; l < CDB_W; l++) begin
        rob_cmpl_valid[l] <= lane_gnt[l];
        cdb_valid[l]      <= lane_gnt[l] & lane_entry[l].has_dst;
        cdb_tag[l]        <= lane_entry[l].dst_tag;
        cdb_value[l]      <= lane_entry[l].value;
        cdb_rob_tag[l]    <= lane_entry[l].rob_tag;
      end
    end
  end

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, has_dst=0, 4-way
// contention with full FIFOs, flush and asynchronous reset mid-burst.
module tb_cdb_arbiter;

  localparam int NUM_FU     = 4;
  localparam int CDB_W      = 2;
  localparam int PHYS_W     = 6;
  localparam int ROB_W      = 6;
  localparam int FIFO_DEPTH = 4;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          flush_pipeline;
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0]             fu_ready;
  logic [NUM_FU-1:0][PHYS_W-1:0] fu_dst_tag;
  logic [NUM_FU-1:0][31:0]       fu_value;
  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_tag;
  logic [NUM_FU-1:0]             fu_has_dst;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag;
  logic [CDB_W-1:0][31:0]        cdb_value;
  logic [CDB_W-1:0][ROB_W-1:0]   cdb_rob_tag;
  logic [CDB_W-1:0]              rob_cmpl_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  cdb_arbiter #(
    .NUM_FU(NUM_FU), .CDB_W(CDB_W), .PHYS_W(PHYS_W), .ROB_W(ROB_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .flush_pipeline(flush_pipeline),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_dst_tag(fu_dst_tag),
    .fu_value(fu_value), .fu_rob_tag(fu_rob_tag), .fu_has_dst(fu_has_dst),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_rob_tag(cdb_rob_tag), .rob_cmpl_valid(rob_cmpl_valid)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fu_valid       = '0;
    fu_has_dst     = '0;
    fu_dst_tag     = '0;
    fu_value       = '0;
    fu_rob_tag     = '0;
    flush_pipeline = 1'b0;
  endtask

  task automatic drive_fu(input int k, input logic [31:0] val, input logic [5:0] tag,
                          input logic [5:0] rob, input logic hd);
    fu_valid[k]   = 1'b1;
    fu_value[k]   = val;
    fu_dst_tag[k] = tag;
    fu_rob_tag[k] = rob;
    fu_has_dst[k] = hd;
  endtask

  // Reset pulse placed between clock edges.
  task automatic apply_reset();
    idle();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
  endtask

  // Accepted-attempt index for the i-th entry of FU0/FU1 and FU2/FU3 in the
  // all-units-pushing scenario (hand-traced occupancy: FU0/1 fill after edge 6,
  // FU2/3 after edge 5, then every other push is refused).
  function automatic int acc_a(input int i);
    return (i <= 6) ? i : 6 + 2 * (i - 6);
  endfunction

  function automatic int acc_b(input int i);
    return (i <= 5) ? i : 5 + 2 * (i - 5);
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b0;
    drive_fu(0, 32'h1111_1111, 6'd1, 6'd1, 1'b1);
    drive_fu(2, 32'h2222_2222, 6'd2, 6'd2, 1'b1);
    tick();
    tick();
    n_cmp++; if (cdb_valid !== 2'b00) begin n_bad++; $display("FAIL reset_cdb_valid: got %b want 00", cdb_valid); end
    n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rob_cmpl: got %b want 00", rob_cmpl_valid); end
    n_cmp++; if (cdb_value !== '0) begin n_bad++; $display("FAIL reset_value: got %h want 0", cdb_value); end
    n_cmp++; if ({cdb_tag, cdb_rob_tag} !== '0) begin n_bad++; $display("FAIL reset_tags: got %h want 0", {cdb_tag, cdb_rob_tag}); end
    n_cmp++; if (fu_ready !== 4'hF) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", fu_ready); end
    idle();
    #2 reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL reset_no_capture: got %b want 00", rob_cmpl_valid); end
  endtask

  task automatic test_single();
    drive_fu(1, 32'hDEAD_BEEF, 6'h05, 6'd3, 1'b1);
    tick();
    idle();
    n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL single_no_bypass: got %b want 00", rob_cmpl_valid); end
    tick();
    n_cmp++; if (cdb_valid !== 2'b01) begin n_bad++; $display("FAIL single_cdb_valid: got %b want 01", cdb_valid); end
    n_cmp++; if (rob_cmpl_valid !== 2'b01) begin n_bad++; $display("FAIL single_rob_cmpl: got %b want 01", rob_cmpl_valid); end
    n_cmp++; if (cdb_tag[0] !== 6'h05) begin n_bad++; $display("FAIL single_tag: got %h want 05", cdb_tag[0]); end
    n_cmp++; if (cdb_value[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_value: got %h want deadbeef", cdb_value[0]); end
    n_cmp++; if (cdb_rob_tag[0] !== 6'd3) begin n_bad++; $display("FAIL single_rob_tag: got %0d want 3", cdb_rob_tag[0]); end
    n_cmp++; if (cdb_value[1] !== 32'h0) begin n_bad++; $display("FAIL single_lane1_data: got %h want 0", cdb_value[1]); end
    tick();
    n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL single_pulse: got %b want 00", rob_cmpl_valid); end
  endtask

  task automatic test_has_dst();
    drive_fu(2, 32'h0000_1234, 6'h07, 6'd9, 1'b0);
    tick();
    idle();
    tick();
    n_cmp++; if (cdb_valid !== 2'b00) begin n_bad++; $display("FAIL nodst_cdb_valid: got %b want 00", cdb_valid); end
    n_cmp++; if (rob_cmpl_valid !== 2'b01) begin n_bad++; $display("FAIL nodst_rob_cmpl: got %b want 01", rob_cmpl_valid); end
    n_cmp++; if (cdb_rob_tag[0] !== 6'd9) begin n_bad++; $display("FAIL nodst_rob_tag: got %0d want 9", cdb_rob_tag[0]); end
    n_cmp++; if (cdb_value[0] !== 32'h0000_1234) begin n_bad++; $display("FAIL nodst_value: got %h want 1234", cdb_value[0]); end
  endtask

  // All four units push every cycle from rr_ptr=0; grants alternate {0,1}/{2,3},
  // FIFOs fill, and refused pushes never reach the bus.
  task automatic test_contention();
    logic [31:0] e0;
    logic [31:0] e1;
    int i;
    apply_reset();
    exp_q.delete();
    for (int n = 1; n <= 20; n++) begin
      if ((n % 2) == 1) begin
        i = (n - 1) / 2;
        exp_q.push_back({16'd0, 16'(acc_a(i))});
        exp_q.push_back({16'd1, 16'(acc_a(i))});
      end else begin
        i = (n - 2) / 2;
        exp_q.push_back({16'd2, 16'(acc_b(i))});
        exp_q.push_back({16'd3, 16'(acc_b(i))});
      end
    end
    for (int e = 0; e <= 20; e++) begin
      if (e < 20) begin
        for (int k = 0; k < NUM_FU; k++)
          drive_fu(k, {16'(k), 16'(e)}, {2'(k), 4'(e)}, 6'(e), 1'b1);
      end else begin
        idle();
      end
      tick();
      if (e >= 1) begin
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        n_cmp++; if (rob_cmpl_valid !== 2'b11 || cdb_valid !== 2'b11) begin n_bad++; $display("FAIL cont_valids edge %0d: got %b/%b want 11/11", e, rob_cmpl_valid, cdb_valid); end
        n_cmp++; if (cdb_value[0] !== e0) begin n_bad++; $display("FAIL cont_lane0 edge %0d: got %h want %h", e, cdb_value[0], e0); end
        n_cmp++; if (cdb_value[1] !== e1) begin n_bad++; $display("FAIL cont_lane1 edge %0d: got %h want %h", e, cdb_value[1], e1); end
        n_cmp++; if (cdb_rob_tag[0] !== e0[5:0]) begin n_bad++; $display("FAIL cont_rob0 edge %0d: got %h want %h", e, cdb_rob_tag[0], e0[5:0]); end
      end
      if (e == 5) begin
        n_cmp++; if (fu_ready !== 4'b0011) begin n_bad++; $display("FAIL cont_ready_e5: got %b want 0011", fu_ready); end
      end
      if (e == 6) begin
        n_cmp++; if (fu_ready !== 4'b1100) begin n_bad++; $display("FAIL cont_ready_e6: got %b want 1100", fu_ready); end
      end
      if (e == 7) begin
        n_cmp++; if (fu_ready !== 4'b0011) begin n_bad++; $display("FAIL cont_ready_e7: got %b want 0011", fu_ready); end
      end
    end
    idle();
  endtask

  task automatic test_flush();
    apply_reset();
    // Move rr_ptr away from 0 with one FU1 result.
    drive_fu(1, 32'h0000_0050, 6'd1, 6'd1, 1'b1);
    tick();
    idle();
    tick();
    tick();
    // Buffer three entries, then flush with a simultaneous FU3 push.
    for (int k = 0; k < 3; k++) drive_fu(k, 32'hBAD0_0000 | 32'(k), 6'(k), 6'(k), 1'b1);
    tick();
    idle();
    flush_pipeline = 1'b1;
    drive_fu(3, 32'hBAD0_0003, 6'd3, 6'd3, 1'b1);
    tick();
    idle();
    n_cmp++; if (cdb_valid !== 2'b00 || rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL flush_valids: got %b/%b want 00/00", cdb_valid, rob_cmpl_valid); end
    n_cmp++; if (fu_ready !== 4'hF) begin n_bad++; $display("FAIL flush_ready: got %b want 1111", fu_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL flush_stale cycle %0d: got %b want 00", c, rob_cmpl_valid); end
    end
    // rr_ptr restarted at 0: units 0,1 win first, then 2,3.
    for (int k = 0; k < NUM_FU; k++) drive_fu(k, 32'h0000_0600 | 32'(k), 6'(k), 6'(k), 1'b1);
    tick();
    idle();
    tick();
    n_cmp++; if (cdb_value[0] !== 32'h600 || cdb_value[1] !== 32'h601) begin n_bad++; $display("FAIL flush_rr_first: got %h %h want 600 601", cdb_value[0], cdb_value[1]); end
    tick();
    n_cmp++; if (cdb_value[0] !== 32'h602 || cdb_value[1] !== 32'h603) begin n_bad++; $display("FAIL flush_rr_second: got %h %h want 602 603", cdb_value[0], cdb_value[1]); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int e = 0; e < 3; e++) begin
      for (int k = 0; k < NUM_FU; k++) drive_fu(k, 32'h0000_0A00 | 32'(e), 6'(k), 6'(e), 1'b1);
      tick();
    end
    n_cmp++; if (rob_cmpl_valid !== 2'b11) begin n_bad++; $display("FAIL areset_burst: got %b want 11", rob_cmpl_valid); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (cdb_valid !== 2'b00 || rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL areset_valids: got %b/%b want 00/00", cdb_valid, rob_cmpl_valid); end
    n_cmp++; if (cdb_value !== '0) begin n_bad++; $display("FAIL areset_value: got %h want 0", cdb_value); end
    n_cmp++; if (fu_ready !== 4'hF) begin n_bad++; $display("FAIL areset_ready: got %b want 1111", fu_ready); end
    tick();
    idle();
    #2 reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rob_cmpl_valid !== 2'b00) begin n_bad++; $display("FAIL areset_lost: got %b want 00", rob_cmpl_valid); end
    drive_fu(3, 32'h0000_0077, 6'h2A, 6'd17, 1'b1);
    tick();
    idle();
    tick();
    n_cmp++; if (cdb_valid !== 2'b01 || cdb_value[0] !== 32'h77) begin n_bad++; $display("FAIL areset_after: got %b %h want 01 77", cdb_valid, cdb_value[0]); end
    n_cmp++; if (cdb_tag[0] !== 6'h2A || cdb_rob_tag[0] !== 6'd17) begin n_bad++; $display("FAIL areset_after_tags: got %h %h want 2a 11", cdb_tag[0], cdb_rob_tag[0]); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_has_dst();
    test_contention();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cdb_arbiter
